// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: I-port, D-port and downstream cache-FSM signals.
// The slave modport is the arbiter's view; the master modport is the requesters/memory side.
interface mem_port_arbiter_if;
  logic        i_rd;
  logic [15:0] i_addr;
  logic [15:0] i_rdata;
  logic        i_ack;
  logic        i_stall;
  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_ack;
  logic        d_stall;
  logic        d_err;
  logic [15:0] m_addr;
  logic [15:0] m_data_in;
  logic        m_rd;
  logic        m_wr;
  logic [15:0] m_data_out;
  logic        m_done;
  logic        m_cachehit;
  logic        m_err;
  logic        hit_out;

  modport slave (
    input  i_rd, i_addr, d_rd, d_wr, d_addr, d_wdata, m_data_out, m_done, m_cachehit, m_err,
    output i_rdata, i_ack, i_stall, d_rdata, d_ack, d_stall, d_err,
    output m_addr, m_data_in, m_rd, m_wr, hit_out
  );

  modport master (
    output i_rd, i_addr, d_rd, d_wr, d_addr, d_wdata, m_data_out, m_done, m_cachehit, m_err,
    input  i_rdata, i_ack, i_stall, d_rdata, d_ack, d_stall, d_err,
    input  m_addr, m_data_in, m_rd, m_wr, hit_out
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of the shared cache subsystem.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default: D wins ties).
module mem_port_arbiter (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t      state, state_nx;
  logic        last_grant;   // 0 = I, 1 = D
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        cmd_rd;
  logic        cmd_wr;

  logic grant_i, grant_d, done, d_req, d_illegal, d_legal, tie_to_d;
  logic i_ack, d_ack, d_err, hit;
  logic [15:0] i_rdata, d_rdata;

  assign d_req     = bus.d_rd | bus.d_wr;
  assign d_illegal = bus.d_rd & bus.d_wr;
  assign d_legal   = d_req & ~d_illegal;
  assign done      = bus.m_done | bus.m_err;

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_to_d = ~last_grant;
`else
  assign tie_to_d = 1'b1;
`endif

  always_comb begin
    state_nx = state;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    i_ack    = 1'b0;
    d_ack    = 1'b0;
    d_err    = 1'b0;
    hit      = 1'b0;
    i_rdata  = 16'h0000;
    d_rdata  = 16'h0000;
    case (state)
      IDLE: begin
        // An illegal D request is rejected on the spot and does not block I.
        if (d_illegal) begin
          d_ack   = 1'b1;
          d_err   = 1'b1;
          grant_i = bus.i_rd;
        end else if (bus.i_rd && d_legal) begin
          grant_d = tie_to_d;
          grant_i = ~tie_to_d;
        end else begin
          grant_d = d_legal;
          grant_i = bus.i_rd;
        end
        if (grant_d)      state_nx = BUSY_D;
        else if (grant_i) state_nx = BUSY_I;
      end
      BUSY_I: begin
        if (done) begin
          i_ack    = 1'b1;
          i_rdata  = bus.m_data_out;
          hit      = bus.m_cachehit;
          state_nx = IDLE;
        end
      end
      BUSY_D: begin
        if (done) begin
          d_ack    = 1'b1;
          d_err    = bus.m_err;
          d_rdata  = bus.m_data_out;
          hit      = bus.m_cachehit;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      cmd_addr   <= 16'h0000;
      cmd_wdata  <= 16'h0000;
      cmd_rd     <= 1'b0;
      cmd_wr     <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant_d) begin
        cmd_addr  <= bus.d_addr;
        cmd_wdata <= bus.d_wdata;
        cmd_rd    <= bus.d_rd;
        cmd_wr    <= bus.d_wr;
      end else if (grant_i) begin
        cmd_addr <= bus.i_addr;
        cmd_rd   <= 1'b1;
        cmd_wr   <= 1'b0;
      end else if (i_ack || (d_ack && state == BUSY_D)) begin
        // Commands drop on the way back to IDLE; address/data keep their last value.
        cmd_rd     <= 1'b0;
        cmd_wr     <= 1'b0;
        last_grant <= (state == BUSY_D);
      end
    end
  end

  assign bus.m_addr    = cmd_addr;
  assign bus.m_data_in = cmd_wdata;
  assign bus.m_rd      = cmd_rd;
  assign bus.m_wr      = cmd_wr;
  assign bus.i_ack     = i_ack;
  assign bus.i_rdata   = i_rdata;
  assign bus.i_stall   = bus.i_rd & ~i_ack;
  assign bus.d_ack     = d_ack;
  assign bus.d_rdata   = d_rdata;
  assign bus.d_err     = d_err;
  assign bus.d_stall   = d_req & ~d_ack;
  assign bus.hit_out   = hit;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single cache/four-bank memory subsystem between two requesters: the instruction-fetch port (I) and the data-memory port (D).
- Accepts level-held requests and forwards exactly one transaction at a time downstream.
- Holds the downstream address, data and command stable until the cache FSM reports done.
- Returns read data, hit and error status to the granted requester with a one-cycle acknowledge.

## Interface
Parameters: none (widths fixed by the memory system: 16-bit address and data).

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk
- i_rd  in  1  I-port read request; level-held until i_ack
- i_addr  in  16  I-port address; stable while i_rd is high
- i_rdata  out  16  I-port read data; valid only with i_ack
- i_ack  out  1  I-port transaction complete (1-cycle pulse)
- i_stall  out  1  i_rd & ~i_ack
- d_rd, d_wr  in  1 each  D-port read/write request; level-held until d_ack
- d_addr, d_wdata  in  16 each  D-port address and write data; stable while requesting
- d_rdata  out  16  D-port read data; valid only with d_ack
- d_ack  out  1  D-port transaction complete (1-cycle pulse)
- d_stall  out  1  (d_rd | d_wr) & ~d_ack
- d_err  out  1  1-cycle pulse: illegal D request, or downstream error on a D transaction
- m_addr, m_data_in  out  16 each  downstream address and write data
- m_rd, m_wr  out  1 each  downstream commands
- m_data_out  in  16  downstream read data
- m_done  in  1  downstream done
- m_cachehit  in  1  downstream hit flag, valid with m_done
- m_err  in  1  downstream error
- hit_out  out  1  m_cachehit forwarded with whichever ack fires

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- Registers: grant command (addr, wdata, rd, wr) and last_grant (I/D).
- IDLE, no request:
  - Stay in IDLE.
  - m_rd = m_wr = 0; m_addr and m_data_in hold their last value.
- IDLE, exactly one legal request: latch that requester's command and go to BUSY_I or BUSY_D.
- IDLE, both requesting: winner chosen per Configuration; the loser stays stalled.
- IDLE, d_rd & d_wr together:
  - Pulse d_err and d_ack for one cycle.
  - Forward nothing; stay in IDLE.
  - A simultaneous legal I request is granted in the same cycle.
- BUSY_x:
  - m_addr, m_data_in, m_rd and m_wr come from registers and are held constant.
  - New requests are ignored.
- BUSY_x with m_done = 1:
  - Pulse x_ack.
  - x_rdata = m_data_out and hit_out = m_cachehit, both in the same cycle.
  - Set last_grant = x; return to IDLE next cycle.
- BUSY_x with m_err = 1 (with or without m_done):
  - Terminate as for m_done.
  - If x = D, also pulse d_err.
  - If x = I, the error is dropped; i_ack still pulses.
- m_done or m_err seen in IDLE: ignored.
- Re-grant: a requester whose request is still high in the cycle after its ack is treated as a new transaction; requesters must drop or update the request after ack.
- Reset values:
  - State IDLE; last_grant = I.
  - All outputs 0, including the m_addr and m_data_in registers.
- Reset mid-transaction: return to IDLE, abandon the downstream transaction, no ack. The memory system shares the same reset.

## Timing
- Request sampled in IDLE in cycle N → m_rd or m_wr high from cycle N+1 (registered outputs).
- m_done at cycle M (M ≥ N+2) → x_ack at M, combinational from state & m_done.
- Back in IDLE at M+1; the next grant drives downstream at M+2.
- Minimum request-to-ack latency: 2 cycles (cache hit). Back-to-back throughput: one transaction per 3 cycles minimum.
- Stall outputs are combinational and drop in the ack cycle.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on a tie, grant the port opposite last_grant. The first tie after reset goes to D.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: D always wins ties.
  - last_grant is still maintained but not used.
  - Continuous D traffic may starve I; this is accepted.

## Test plan
- I read of 0x0040, downstream m_done at third BUSY cycle with m_data_out = 0xBEEF, m_cachehit = 1 → m_rd high and m_addr = 0x0040 held every BUSY cycle; i_ack, i_rdata = 0xBEEF and hit_out pulse together; i_stall low after.
- D write 0x1234 → 0x2000 raised together with I read 0x0010, with ARB_ROUND_ROBIN_EN → D granted first (m_wr = 1, m_data_in = 0x1234); I granted at the cycle after d_ack + 1; the next tie goes to I.
- Same tie without the macro, D re-requesting continuously → D granted every time; i_stall remains 1.
- d_rd = d_wr = 1 in IDLE → d_err and d_ack pulse one cycle; m_rd = m_wr = 0 throughout.
- BUSY_D with m_err = 1 → d_ack and d_err pulse; IDLE next cycle.
- rst low during BUSY_I → next cycle state IDLE, all outputs 0, no i_ack; re-request completes normally.
